// File: rtl/branch_predictor_bht_if.sv
// Fetch-lookup and MEM-resolve signal bundle for the branch history table.
// The slave side is the predictor; the master side is the pipeline.
interface branch_predictor_bht_if #(
    parameter int PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] if_pc;
    logic                if_predict;
    logic                mem_valid;
    logic [PC_WIDTH-1:0] mem_pc;
    logic                mem_branch;
    logic                mem_branch_en;
    logic                mem_predicted;
    logic                mem_jump;
    logic                decision;
    logic                mistake;
    logic                branch_jump_trig;

    modport master (
        output if_pc, mem_valid, mem_pc, mem_branch,
        output mem_branch_en, mem_predicted, mem_jump,
        input  if_predict, decision, mistake, branch_jump_trig
    );

    modport slave (
        input  if_pc, mem_valid, mem_pc, mem_branch,
        input  mem_branch_en, mem_predicted, mem_jump,
        output if_predict, decision, mistake, branch_jump_trig
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// PC-indexed table of saturating counters: zero-latency lookup for IF,
// MEM-stage resolve and training, plus branch/mispredict statistics.
module branch_predictor_bht #(
    parameter int PC_WIDTH   = 32,
    parameter int IDX_BITS   = 4,
    parameter int CTR_WIDTH  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_predictor_bht_if.slave bus,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);
    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT =
        CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

    logic [CTR_WIDTH-1:0] bht [DEPTH];
    logic [IDX_BITS-1:0]  ridx;
    logic [IDX_BITS-1:0]  widx;
    logic [CTR_WIDTH-1:0] cur;
    logic [CTR_WIDTH-1:0] nxt;
    logic                 train;
    logic                 miss;

    assign ridx = bus.if_pc[IDX_BITS+1:2];
    assign widx = bus.mem_pc[IDX_BITS+1:2];

    // Untagged index: PC bits outside the index field are ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.if_pc[PC_WIDTH-1:IDX_BITS+2],
                              bus.if_pc[1:0],
                              bus.mem_pc[PC_WIDTH-1:IDX_BITS+2],
                              bus.mem_pc[1:0]};

    assign bus.if_predict = bht[ridx][CTR_WIDTH-1];

    assign bus.decision = bus.mem_valid & bus.mem_branch
                        & bus.mem_branch_en;
    assign bus.mistake = bus.mem_valid & bus.mem_branch
                       & bus.mem_predicted & ~bus.mem_branch_en;
    assign bus.branch_jump_trig =
        (bus.mem_valid & bus.mem_branch & ~bus.mem_predicted
         & bus.mem_branch_en)
        | (bus.mem_valid & bus.mem_jump);

    assign train = bus.mem_valid & bus.mem_branch;
    assign miss  = bus.mistake
                 | (bus.branch_jump_trig & ~bus.mem_jump);
    assign cur   = bht[widx];

    always_comb begin
        nxt = cur;
        if (bus.mem_branch_en) begin
            if (cur != CTR_MAX) nxt = cur + CTR_WIDTH'(1);
        end else begin
            if (cur != '0) nxt = cur - CTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) bht[i] <= CTR_INIT;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (train) begin
            bht[widx]    <= nxt;
            branch_count <= branch_count + STAT_WIDTH'(1);
            if (miss) mispredict_count <= mispredict_count + STAT_WIDTH'(1);
        end
    end
endmodule
